bsg_reduce_segmented_accum: RTL

//   Streaming, multi-beat successor to the combinational segmented reducer.
//   - Each accepted beat carries segments_p segments, each segment_width_p bits wide.
//   - Every segment is reduced to one bit with op_p (AND/OR/XOR).
//   - Per-segment results accumulate across beats until the beat marked last_i.
//   - The packet result is presented in a one-entry output register with a

---
 rtl/bsg_reduce_segmented_accum_if.sv | 19 +
 rtl/bsg_reduce_segmented_accum.sv | 70 +++++++
 2 files changed

// File: rtl/bsg_reduce_segmented_accum_if.sv
// bsg_reduce_segmented_accum_if: beat input stream plus registered packet-result handshake
interface bsg_reduce_segmented_accum_if #(
  parameter int segments_p      = 5,
  parameter int segment_width_p = 32,
  parameter int max_beats_p     = 16
);
  localparam int bw = $clog2(max_beats_p + 1);
  logic                                  v_i;
  logic [segments_p*segment_width_p-1:0] data_i;
  logic                                  last_i;
  logic                                  ready_o;
  logic                                  v_o;
  logic [segments_p-1:0]                 data_o;
  logic [bw-1:0]                         beats_o;
  logic                                  ovf_o;
  logic                                  yumi_i;
  modport slave (input v_i, data_i, last_i, yumi_i, output ready_o, v_o, data_o, beats_o, ovf_o);
  modport master (output v_i, data_i, last_i, yumi_i, input ready_o, v_o, data_o, beats_o, ovf_o);
endinterface

// File: rtl/bsg_reduce_segmented_accum.sv
// bsg_reduce_segmented_accum: per-segment AND/OR/XOR reduction accumulated over multi-beat packets
module bsg_reduce_segmented_accum #(
  parameter int segments_p      = 5,
  parameter int segment_width_p = 32,
  parameter int op_p            = 0,
  parameter int max_beats_p     = 16
) (
  input logic clk_i,
  input logic reset_i,
  bsg_reduce_segmented_accum_if.slave bus
);
  localparam int bw = $clog2(max_beats_p + 1);
  localparam logic [segments_p-1:0] ident = {segments_p{op_p == 0}};
  localparam logic [bw-1:0] cnt_max = bw'(max_beats_p);
  if (op_p < 0 || op_p > 2) begin : g_bad_op
    $error("op_p must be 0 (AND), 1 (OR) or 2 (XOR)");
  end
  logic [segments_p-1:0] red, nxt, acc_q, acc_d, data_q, data_d;
  logic [bw-1:0] cnt_q, cnt_d, cnt_nxt, beats_q, beats_d;
  logic ovf_q, ovf_d, ovf_nxt, ovfo_q, ovfo_d, v_q, v_d, ready, take, fin;
  // reduce each segment of the beat and fold it into the running accumulator
  always_comb begin
    red = '0;
    for (int k = 0; k < segments_p; k++)
      red[k] = op_p == 0 ? &bus.data_i[k*segment_width_p +: segment_width_p]
             : op_p == 1 ? |bus.data_i[k*segment_width_p +: segment_width_p]
             :             ^bus.data_i[k*segment_width_p +: segment_width_p];
    nxt = op_p == 0 ? acc_q & red : op_p == 1 ? acc_q | red : acc_q ^ red;
  end
  // packet bookkeeping: the last beat moves the result to the output register and re-arms the accumulator
  always_comb begin
    ready   = ~v_q | bus.yumi_i;
    take    = bus.v_i & ready;
    fin     = take & bus.last_i;
    cnt_nxt = cnt_q == cnt_max ? cnt_q : cnt_q + 1'b1;
    ovf_nxt = ovf_q | (cnt_q == cnt_max);
    acc_d   = fin ? ident : take ? nxt : acc_q;
    cnt_d   = fin ? '0 : take ? cnt_nxt : cnt_q;
    ovf_d   = fin ? 1'b0 : take ? ovf_nxt : ovf_q;
    v_d     = fin | (v_q & ~bus.yumi_i);
    data_d  = fin ? nxt : data_q;
    beats_d = fin ? cnt_nxt : beats_q;
    ovfo_d  = fin ? ovf_nxt : ovfo_q;
  end
  // state and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= ident;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      v_q     <= 1'b0;
      data_q  <= '0;
      beats_q <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      v_q     <= v_d;
      data_q  <= data_d;
      beats_q <= beats_d;
      ovfo_q  <= ovfo_d;
    end
  end
  assign bus.ready_o = ready;
  assign bus.v_o     = v_q;
  assign bus.data_o  = data_q;
  assign bus.beats_o = beats_q;
  assign bus.ovf_o   = ovfo_q;
endmodule
